instr_encoder: RTL and testbench
================================

# instr_encoder

Converts a stream of symbolic instruction requests (operation code plus register/immediate/target fields) into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It is the encoding counterpart of the pipeline's instruction decoder, covering the same instruction subset. It sits between the test/boot program loader and the IM write port. A small FIFO decouples request acceptance from memory backpressure.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 4
- ADDR_W, 10: IM word-address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request may be accepted this cycle
- req_op  in  4  0 NOP, 1 ADDU, 2 SUBU, 3 AND, 4 OR, 5 SLT, 6 JR, 7 LW, 8 SW, 9 BEQ, 10 ORI, 11 LUI, 12 J, 13 JAL, 14–15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  16  immediate / branch offset
- req_target  in  26  jump target field
- im_we  out  1  IM write valid
- im_ready  in  1  IM accepts write this cycle
- im_addr  out  ADDR_W  word address of current write
- im_wdata  out  32  encoded instruction
- words_written  out  32  count of completed IM writes
- err_illegal  out  1  sticky: an illegal req_op was accepted

## Operation
- Accept: req_valid && req_ready at a rising edge.
- Encoding, written on accept:
  - R-type: {6'b0, rs, rt, rd, 5'b0, funct}; funct ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLT 0x2A.
  - JR: {6'b0, rs, 15'b0, 6'h08}. NOP: 32'h0.
  - I-type: {opcode, rs, rt, imm}; opcode LW 0x23, SW 0x2B, BEQ 0x04, ORI 0x0D, LUI 0x0F. LUI forces rs=0.
  - J-type: {opcode, target}; opcode J 0x02, JAL 0x03.
  - For each op, unused fields are forced to zero regardless of inputs.
- Illegal op (14, 15):
  - Handshake completes.
  - Nothing is pushed.
  - err_illegal sets next cycle and holds until reset.
- FIFO:
  - Circular, DEPTH entries, with read/write pointers and an occupancy count (width log2(DEPTH)+1).
  - Push and pop may occur in the same cycle; occupancy = count + pushes − pops.
- Drain:
  - im_we = (count != 0).
  - im_wdata = head entry.
  - A write completes when im_we && im_ready.
  - On each completed write, im_addr increments, wrapping 2^ADDR_W−1 → 0, and words_written increments, wrapping at 2^32.
- req_ready = reset && (count ≤ DEPTH−1). It is derived from registered count only, with no combinational path from im_ready or req_*. A pop in the same cycle does not raise req_ready.

## Timing
- Reset values: req_ready 0 while reset is low, 1 in the first cycle after release. im_we 0, im_addr 0, im_wdata 0, words_written 0, err_illegal 0. Pointers and count 0; FIFO contents discarded.
- Reset mid-operation: queued words are dropped and the address restarts at 0. A write presented in the reset cycle does not complete.
- Latency: a request accepted at edge N gives im_we=1 with its word during cycle N+1, at the earliest.
- Throughput: 1 word per cycle sustained with im_ready held at 1.
- Backpressure: while im_ready=0, im_we, im_addr and im_wdata hold stable.
- Full: when count=DEPTH, req_ready=0. Requests are not lost; the producer holds them.

## Configuration
- ENC_DELAY_SLOT_EN defined:
  - Every accepted BEQ, J, JAL or JR pushes two entries in one cycle: the encoded word, then 32'h0 (delay-slot NOP).
  - req_ready requires count ≤ DEPTH−2 for all ops.
  - words_written counts both words.
- ENC_DELAY_SLOT_EN undefined: one entry per accepted legal op; req_ready rule as above.

## Test plan
- ADDU rs=1 rt=2 rd=3, im_ready=1 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221821; words_written=1 after the write completes.
- LUI rt=5 imm=0x1234 with req_rs=7, then ORI rs=5 rt=5 imm=0xABCD -> 0x3C051234 at addr 0, 0x34A5ABCD at addr 1.
- im_ready=0, push SW words back-to-back -> req_ready falls after 4 accepts (after 3 with macro defined). Outputs stay stable; raising im_ready drains addrs 0–3 in order, one per cycle.
- BEQ rs=1 rt=2 imm=0xFFFF then JAL target=0x0000C00 -> with macro: 0x1022FFFF, 0, 0x0C000C00, 0 at addrs 0–3. Without macro: 0x1022FFFF, 0x0C000C00 at addrs 0–1.
- req_op=15 accepted -> no im_we, err_illegal=1 next cycle and stays 1 through later legal ops; cleared only by reset.
- 3 words queued, im_ready=0, reset low 1 cycle -> im_we=0, im_addr=0, words_written=0, req_ready=1 after release. Next ADDU is written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and streams them into IM through a small FIFO.
// Optional ENC_DELAY_SLOT_EN: each branch/jump also queues a delay-slot NOP behind its word.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       words_written,
    output logic              err_illegal
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_ADDU = 4'd1,  OP_SUBU = 4'd2,  OP_AND = 4'd3,
        OP_OR   = 4'd4,  OP_SLT  = 4'd5,  OP_JR   = 4'd6,  OP_LW  = 4'd7,
        OP_SW   = 4'd8,  OP_BEQ  = 4'd9,  OP_ORI  = 4'd10, OP_LUI = 4'd11,
        OP_J    = 4'd12, OP_JAL  = 4'd13
    } op_e;

    function automatic logic [31:0] encode(input op_e op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] imm,
                                           input logic [25:0] target);
        case (op)
            OP_ADDU: encode = {6'h00, rs, rt, rd, 5'b0, 6'h21};
            OP_SUBU: encode = {6'h00, rs, rt, rd, 5'b0, 6'h23};
            OP_AND:  encode = {6'h00, rs, rt, rd, 5'b0, 6'h24};
            OP_OR:   encode = {6'h00, rs, rt, rd, 5'b0, 6'h25};
            OP_SLT:  encode = {6'h00, rs, rt, rd, 5'b0, 6'h2A};
            OP_JR:   encode = {6'h00, rs, 15'b0, 6'h08};
            OP_LW:   encode = {6'h23, rs, rt, imm};
            OP_SW:   encode = {6'h2B, rs, rt, imm};
            OP_BEQ:  encode = {6'h04, rs, rt, imm};
            OP_ORI:  encode = {6'h0D, rs, rt, imm};
            OP_LUI:  encode = {6'h0F, 5'b0, rt, imm};
            OP_J:    encode = {6'h02, target};
            OP_JAL:  encode = {6'h03, target};
            default: encode = 32'h0;
        endcase
    endfunction

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   push_n;
    logic             accept, legal, push, pop, has_slot;
    logic [31:0]      enc_word;
    op_e              op;

    assign op = op_e'(req_op);

`ifdef ENC_DELAY_SLOT_EN
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
    assign has_slot = (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
`else
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 1);
    assign has_slot = 1'b0;
`endif

    // Ready looks only at registered occupancy, so a same-cycle pop never raises it.
    assign req_ready = reset && (count <= READY_MAX);
    assign accept    = req_valid && req_ready;
    assign legal     = (req_op < 4'd14);
    assign push      = accept && legal;
    assign im_we     = (count != '0);
    assign pop       = im_we && im_ready;
    assign im_wdata  = im_we ? mem[rd_ptr] : 32'h0;
    assign enc_word  = encode(op, req_rs, req_rt, req_rd, req_imm, req_target);

    always_comb begin
        // NOTE: default assignment first so no path leaves push_n unassigned (no latch).
        push_n = '0;
        if (push) push_n = has_slot ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            im_addr       <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
            count  <= count + push_n - (PTR_W+1)'(pop);
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                im_addr       <= im_addr + ADDR_W'(1);
                words_written <= words_written + 32'd1;
            end
            if (accept && !legal) err_illegal <= 1'b1;
        end
    end

    // NOTE: storage is not reset; zero occupancy already marks every entry as invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
            if (has_slot) mem[wr_ptr + PTR_W'(1)] <= 32'h0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected IM words queued at accept time, compared as each write completes.
// Builds with or without ENC_DELAY_SLOT_EN; expectations follow the macro.
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam bit SLOT =
`ifdef ENC_DELAY_SLOT_EN
        1'b1;
`else
        1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = '0;
    logic [4:0]        req_rs = '0, req_rt = '0, req_rd = '0;
    logic [15:0]       req_imm = '0;
    logic [25:0]       req_target = '0;
    logic              im_we;
    logic              im_ready = 1'b0;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [31:0]       words_written;
    logic              err_illegal;

    int                n_vec = 0;
    int                n_err = 0;
    logic [31:0]       sb[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_ww = '0;

    instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .im_we(im_we), .im_ready(im_ready),
        .im_addr(im_addr), .im_wdata(im_wdata), .words_written(words_written),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every completed write must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && im_we && im_ready) begin
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                check("im_wdata", im_wdata, sb.pop_front());
                check("im_addr", 32'(im_addr), 32'(exp_addr));
                check("words_written_before", words_written, exp_ww);
                exp_addr = exp_addr + ADDR_W'(1);
                exp_ww   = exp_ww + 32'd1;
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_words_written", words_written, 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        sb.delete();
        exp_addr = '0;
        exp_ww   = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 32'(req_ready), 32'd1);
        check("rel_im_we", 32'(im_we), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp, input bit slot);
        int waited = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (op < 4'd14) begin
            sb.push_back(exp);
            if (SLOT && slot) sb.push_back(32'h0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int accepts;
        repeat (2) @(posedge clk);
        #1;
        reset_dut();

        // ADDU, first-write latency and counter
        im_ready = 1'b1;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1821, 1'b0);
        @(negedge clk);
        check("lat_im_we", 32'(im_we), 32'd1);
        check("lat_im_wdata", im_wdata, 32'h0022_1821);
        check("lat_im_addr", 32'(im_addr), 32'd0);
        drain();
        check("addu_words_written", words_written, 32'd1);

        // LUI ignores rs, then ORI
        reset_dut();
        im_ready = 1'b1;
        send(4'd11, 5'd7, 5'd5, 5'd9, 16'h1234, 26'h3FF_FFFF, 32'h3C05_1234, 1'b0);
        send(4'd10, 5'd5, 5'd5, 5'd31, 16'hABCD, 26'h0, 32'h34A5_ABCD, 1'b0);
        drain();
        check("lui_ori_words", words_written, 32'd2);

        // Backpressure and full FIFO
        reset_dut();
        im_ready = 1'b0;
        accepts = 0;
        req_op = 4'd8; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd0; req_imm = 16'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!req_ready) break;
            @(posedge clk); #1;
            sb.push_back(32'hAC22_0000 + 32'(accepts));
            accepts++;
            req_imm = 16'(accepts);
        end
        req_valid = 1'b0;
        check("full_accepts", 32'(accepts), SLOT ? 32'd3 : 32'd4);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            check("stall_im_we", 32'(im_we), 32'd1);
            check("stall_im_addr", 32'(im_addr), 32'd0);
            check("stall_im_wdata", im_wdata, 32'hAC22_0000);
        end
        @(posedge clk); #1;
        im_ready = 1'b1;
        repeat (accepts) @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_rate_empty", 32'(sb.size()), 32'd0);
        check("drain_rate_im_we", 32'(im_we), 32'd0);
        check("drain_words", words_written, 32'(accepts));
        @(posedge clk); #1;

        // BEQ then JAL, delay slots when enabled
        reset_dut();
        im_ready = 1'b1;
        send(4'd9, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b1);
        send(4'd13, 5'd4, 5'd5, 5'd6, 16'h5555, 26'h000_0C00, 32'h0C00_0C00, 1'b1);
        drain();
        check("branch_words", words_written, SLOT ? 32'd4 : 32'd2);

        // Illegal op: sticky error, nothing written
        reset_dut();
        im_ready = 1'b1;
        send(4'd15, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 32'h0, 1'b0);
        @(negedge clk);
        check("illegal_im_we", 32'(im_we), 32'd0);
        check("illegal_err", 32'(err_illegal), 32'd1);
        @(posedge clk); #1;
        send(4'd2, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 32'h0064_2823, 1'b0);
        drain();
        check("illegal_err_sticky", 32'(err_illegal), 32'd1);
        check("illegal_words", words_written, 32'd1);

        // Reset with words queued drops them; a write offered in the reset cycle does not count
        im_ready = 1'b0;
        send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0021_0824, 1'b0);
        send(4'd4, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 32'h0042_1025, 1'b0);
        send(4'd5, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 32'h0063_182A, 1'b0);
        im_ready = 1'b1;
        reset_dut();
        check("post_rst_words", words_written, 32'd0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1821, 1'b0);
        drain();
        check("post_rst_addr", 32'(im_addr), 32'd1);
        check("post_rst_count", words_written, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
